// File: rtl/vect_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vect_mem_pkg
//  Description : Shared lane/vector types and bank-row helper for the
//                banked vector memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package vect_mem_pkg;

    localparam int          LANES     = 16;
    localparam int          LANE_W    = 16;
    localparam int          VEC_W     = LANES * LANE_W;
    localparam int unsigned LANE_BITS = $clog2(LANES);

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] vec_t;

    // Row touched in bank b by a vector access starting at element a. Banks
    // below the start lane have already wrapped into the following row.
    function automatic int unsigned bank_row(input logic [31:0] a,
                                             input int unsigned b,
                                             input int unsigned depth);
        int unsigned rows;
        int unsigned base;
        int unsigned carry;
        rows  = depth >> LANE_BITS;
        base  = 32'(a >> LANE_BITS);
        carry = (b < 32'(a[LANE_BITS-1:0])) ? 32'd1 : 32'd0;
        return (base + carry) & (rows - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vect_manager_if.sv
`default_nettype none
// ============================================================================
//  Module      : vect_manager_if
//  Description : Vector access bus between the load/store unit and the
//                vector memory (write enable, element address, data).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vect_manager_if;
    import vect_mem_pkg::*;

    logic        we;
    logic [31:0] a;
    vec_t        wd;
    vec_t        rd;

    modport master (output we, output a, output wd, input  rd);
    modport slave  (input  we, input  a, input  wd, output rd);

endinterface
`default_nettype wire

// File: rtl/vect_rotate.sv
`default_nettype none
// ============================================================================
//  Module      : vect_rotate
//  Description : 16-lane barrel rotator. ROT_UP=1 moves lane i to lane
//                i+sh, ROT_UP=0 moves lane i+sh to lane i (both mod 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module vect_rotate
    import vect_mem_pkg::*;
#(
    parameter bit ROT_UP = 1'b1
) (
    input  vec_t                 i_vec,
    input  logic [LANE_BITS-1:0] i_sh,
    output vec_t                 o_vec
);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam logic [LANE_BITS-1:0] c_idx = LANE_BITS'(i);
            logic [LANE_BITS-1:0] w_src;

            // Index arithmetic is LANE_BITS wide, so the modulo is free.
            if (ROT_UP) begin : g_up
                assign w_src = c_idx - i_sh;
            end else begin : g_dn
                assign w_src = c_idx + i_sh;
            end

            assign o_vec[i] = i_vec[w_src];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vect_manager.sv
`default_nettype none
// ============================================================================
//  Module      : vect_manager
//  Description : Element-addressed 16-lane vector memory, one synchronous
//                write port and one combinational read port, unaligned and
//                wrapping accesses served by 16 interleaved banks.
//  Revision    : 1.0 - initial release
// ============================================================================
module vect_manager
    import vect_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic           clk,
    input  logic           rst,
    vect_manager_if.slave  bus
);

    localparam int c_rows  = DEPTH_WORDS / LANES;
    localparam int c_row_w = (c_rows > 1) ? $clog2(c_rows) : 1;

    logic [LANE_BITS-1:0] w_sh;
    vec_t                 w_wbank;
    vec_t                 w_rbank;
    vec_t                 w_rd;
    logic [c_row_w-1:0]   w_row [LANES];
    logic [LANES-1:0]     w_bank_we;

    // Start lane of the access; upper address bits only select rows.
    assign w_sh = bus.a[LANE_BITS-1:0];

    // Write data: lane i lands in bank (i + sh) mod 16.
    vect_rotate #(
        .ROT_UP (1'b1)
    ) u_wr_rot (
        .i_vec  (bus.wd),
        .i_sh   (w_sh),
        .o_vec  (w_wbank)
    );

    // Read data: lane i comes from bank (i + sh) mod 16.
    vect_rotate #(
        .ROT_UP (1'b0)
    ) u_rd_rot (
        .i_vec  (w_rbank),
        .i_sh   (w_sh),
        .o_vec  (w_rd)
    );

    assign bus.rd = w_rd;

    generate
        for (genvar b = 0; b < LANES; b++) begin : g_bank
            lane_t r_mem [c_rows];

            assign w_row[b]     = c_row_w'(bank_row(bus.a, b, DEPTH_WORDS));
            assign w_bank_we[b] = bus.we;

            // Asynchronous clear takes priority, so a write whose edge falls
            // inside a reset pulse is dropped.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int r = 0; r < c_rows; r++) begin
                        r_mem[r] <= '0;
                    end
                end else if (w_bank_we[b]) begin
                    r_mem[w_row[b]] <= w_wbank[b];
                end
            end

            assign w_rbank[b] = r_mem[w_row[b]];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vect_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vect_manager
//  Description : Self-checking bench for vect_manager against a flat
//                element-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vect_manager;
    import vect_mem_pkg::*;

    localparam int D = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vect_manager_if bus ();

    vect_manager #(
        .DEPTH_WORDS (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lane_t model [D];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int eidx(input logic [31:0] a, input int i);
        return int'((a + 32'(i)) & 32'(D - 1));
    endfunction

    function automatic vec_t model_read(input logic [31:0] a);
        vec_t r;
        for (int i = 0; i < LANES; i++) r[i] = model[eidx(a, i)];
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input vec_t v);
        for (int i = 0; i < LANES; i++) model[eidx(a, i)] = v[i];
    endtask

    task automatic model_clear();
        for (int e = 0; e < D; e++) model[e] = '0;
    endtask

    function automatic vec_t rand_vec();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom;
        return vec_t'(t);
    endfunction

    task automatic read_check(input string tag, input logic [31:0] a);
        bus.a = a;
        #1;
        check(tag, bus.rd, model_read(a));
    endtask

    task automatic do_write(input logic [31:0] a, input vec_t v);
        @(negedge clk);
        bus.we = 1'b1;
        bus.a  = a;
        bus.wd = v;
        @(posedge clk);
        #1;
        model_write(a, v);
        bus.we = 1'b0;
    endtask

    initial begin
        vec_t pat, pat7, v, exp;
        logic [31:0] ra;
        logic        rwe;

        bus.we = 1'b0;
        bus.a  = '0;
        bus.wd = '0;
        rst    = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Populate so that the clear is observable.
        for (int k = 0; k < 8; k++) do_write($urandom, rand_vec());
        do_write(32'd0, rand_vec());
        do_write(32'd1000, rand_vec());
        read_check("pre_rst_a0", 32'd0);

        // Asynchronous reset mid-cycle.
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        bus.a = 32'd0;    #1; check("rst_a0",    bus.rd, '0);
        bus.a = 32'd7;    #1; check("rst_a7",    bus.rd, '0);
        bus.a = 32'd1000; #1; check("rst_a1000", bus.rd, '0);

        // Write attempted while reset is held.
        @(negedge clk);
        bus.we = 1'b1;
        bus.a  = 32'd3;
        bus.wd = rand_vec();
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.a = 32'd3; #1; check("rst_we_blocked", bus.rd, '0);

        // Reset raised between setup and the write edge.
        @(negedge clk);
        bus.we = 1'b1;
        bus.a  = 32'd40;
        bus.wd = rand_vec();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.a = 32'd40; #1; check("rst_mid_write", bus.rd, '0);

        // Aligned and unaligned reads.
        pat  = vec_t'({4{64'hF55F_6F6B_4AA8_6F6B}});
        pat7 = vec_t'({4{64'h6F6B_4AA8_6F6B_F55F}});
        do_write(32'd0, pat);
        do_write(32'd16, pat);
        bus.a = 32'd0;  #1; check("aligned_a0",  bus.rd, pat);
        bus.a = 32'd16; #1; check("aligned_a16", bus.rd, pat);
        bus.a = 32'd7;  #1; check("unaligned_a7", bus.rd, pat7);

        // Unaligned write.
        for (int i = 0; i < LANES; i++) v[i] = lane_t'(16'h1000 + i);
        do_write(32'd5, v);
        bus.a = 32'd5; #1; check("uwr_a5", bus.rd, v);
        exp = pat;
        for (int i = 5; i < LANES; i++) exp[i] = lane_t'(16'h1000 + i - 5);
        bus.a = 32'd0; #1; check("uwr_a0", bus.rd, exp);
        exp = pat;
        for (int i = 0; i < 5; i++) exp[i] = lane_t'(16'h100B + i);
        bus.a = 32'd16; #1; check("uwr_a16", bus.rd, exp);

        // Wrap-around and ignored upper address bits.
        for (int i = 0; i < LANES; i++) v[i] = lane_t'(16'hA000 + i);
        do_write(32'(D - 8), v);
        exp = model_read(32'd0);
        for (int i = 0; i < 8; i++) exp[i] = lane_t'(16'hA008 + i);
        bus.a = 32'd0; #1; check("wrap_a0", bus.rd, exp);
        bus.a = 32'h8000_0000 + 32'(D - 8); #1; check("wrap_upper", bus.rd, v);
        read_check("wrap_last", 32'(D - 1));

        // we=0 leaves contents untouched.
        @(negedge clk);
        bus.we = 1'b0;
        bus.wd = '1;
        repeat (3) @(posedge clk);
        #1;
        read_check("we0_a0",  32'd0);
        read_check("we0_a16", 32'd16);
        read_check("we0_wrap", 32'(D - 8));

        // Read-during-write: old data until the edge, new data after.
        @(negedge clk);
        v      = rand_vec();
        bus.we = 1'b1;
        bus.a  = 32'd16;
        bus.wd = v;
        #1;
        check("rdw_old", bus.rd, model_read(32'd16));
        @(posedge clk);
        #1;
        model_write(32'd16, v);
        check("rdw_new", bus.rd, v);
        bus.we = 1'b0;

        // Randomised traffic, biased toward the wrap region.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rwe = 1'($urandom_range(0, 1));
            ra  = $urandom;
            if ($urandom_range(0, 3) == 0)
                ra = {ra[31:10], 10'(D - 1 - int'($urandom_range(0, 15)))};
            v      = rand_vec();
            bus.we = rwe;
            bus.a  = ra;
            bus.wd = v;
            #1;
            check("rnd_pre", bus.rd, model_read(ra));
            @(posedge clk);
            #1;
            if (rwe) model_write(ra, v);
            check("rnd_post", bus.rd, model_read(ra));
            bus.we = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vect_manager.md
Name: vect_manager

Overview:
- Word-addressed vector memory for the vector datapath: 16 lanes × 16-bit elements = 256-bit vectors.
- Serves the vector load/store unit in the memory stage.
- One synchronous vector write port and one combinational vector read port.
- Any element address is legal: accesses need not be aligned to 16, and they wrap around the end of memory.

Parameters:
- DEPTH_WORDS, 1024, total number of 16-bit elements; must be a power of two and a multiple of 16.
- LANES, 16, elements per vector (fixed; the bank count equals LANES).
- LANE_W, 16, element width in bits.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable, sampled on the rising edge of clk.
- a  input  32  element (16-bit word) address of lane 0; the address is taken modulo DEPTH_WORDS.
- wd  input  256  write vector; lane i = wd[16i+15:16i].
- rd  output  256  read vector; lane i = rd[16i+15:16i].

Behaviour:
- Address mapping:
  - Lane i of an access at address a maps to element E(i) = (a + i) mod DEPTH_WORDS.
  - Lane 0 occupies the least-significant 16 bits.
- Storage organisation:
  - 16 banks; element w lives in bank w mod 16, row w / 16.
  - For an access, bank b holds lane (b − a mod 16) mod 16.
  - The row for bank b is row(a) when b ≥ a mod 16, otherwise row(a)+1 (mod DEPTH_WORDS/16).
- Write:
  - On the rising edge of clk with we=1 and rst=0, all 16 elements E(0..15) are updated from wd.
  - we=0 leaves the memory unchanged.
  - No partial or masked writes.
- Read:
  - rd is purely combinational from a and the current memory contents, so there is zero-cycle latency.
  - Lane i of rd = mem[E(i)].
- Read-during-write:
  - rd reflects the pre-edge contents until the write edge.
  - From the edge onward, rd shows the new data. There is no write-through bypass.
- Wrap-around: an access with a mod DEPTH_WORDS > DEPTH_WORDS−16 spans the last and first rows (e.g. lane 15 of a = DEPTH_WORDS−1 maps to element 14).
- Upper address bits: address bits at or above log2(DEPTH_WORDS) are ignored.
- Reset:
  - rst=1 asynchronously clears every element to 0x0000, so rd reads all zeros while rst is held.
  - Writes are blocked while rst=1.
  - Reset asserted mid-write (at or before the edge) suppresses that write.
- X-safety: we=X or an unknown address is not required to be handled; the bench drives defined values.

Decomposition:
- Package vect_mem_pkg:
  - constants LANES=16, LANE_W=16, VEC_W=256;
  - typedef lane_t (logic [15:0]);
  - typedef vec_t (lane_t [15:0]);
  - helper function bank_row(a, b).
- Sub-module vect_rotate: a 16-lane barrel rotator parameterised by direction and driven by a mod 16.
  - Used on the write path to align wd to banks.
  - Used on the read path to align bank outputs to lanes.
- The top level contains the 16 bank arrays, the per-bank row computation, and write-enable fan-out.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → rd = 0 immediately for a = 0, 7 and 1000; a write attempted with we=1 while rst=1 leaves the memory at 0.
- Aligned write/read: write wd = 0xF55F_6F6B_4AA8_6F6B repeated 4× at a=0, then the same at a=16 → reading a=0 and a=16 returns the written vectors exactly.
- Unaligned read: after the two writes above, read a=7 → lanes 0..3 = 0xF55F, 0x6F6B, 0x4AA8, 0x6F6B, repeating every 4 lanes across all 16 lanes (elements 7..22).
- Unaligned write: write lane i = 0x1000+i at a=5 → reading a=5 returns the same values; reading a=0 gives lanes 5..15 = 0x1000..0x100A and lanes 0..4 unchanged; reading a=16 gives lanes 0..4 = 0x100B..0x100F.
- Wrap-around: write lane i = 0xA000+i at a=DEPTH_WORDS−8 → a=0 reads lanes 0..7 = 0xA008..0xA00F; a=2^31+DEPTH_WORDS−8 reads back the full vector, showing upper address bits are ignored.
- we=0 / read-during-write:
  - With we=0 and wd=0xFFFF…, clock several edges → contents unchanged.
  - With we=1, rd reads the old value before the edge and the new value after it.
